// File: rtl/multi_ch_serial_out_pkg.sv
// Shared encodings and constants for the multi-channel pattern serializer.
package multi_ch_serial_out_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } disp_state_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam logic ONE_SHOT = 1'b0;
  localparam logic REPEAT   = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_ch_serial_out_ch.sv
// Single serial channel: shadow pattern registers plus an LSB-first shifter
// with per-bit fast/slow period selection.
module serial_out_ch
  import multi_ch_serial_out_pkg::*;
#(
  parameter int unsigned DATA_BIT  = 32,
  parameter int unsigned TICK_SLOW = 63,
  parameter int unsigned TICK_FAST = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic [DATA_BIT-1:0] wr_out,
  input  logic [DATA_BIT-1:0] wr_freq,
  input  logic                wr_mode,
  input  logic                start,
  input  logic                stop,
  output logic                serial_out,
  output logic                bit_tick,
  output logic                done_tick,
  output logic                busy
);

  localparam int unsigned TICK_MAX = max_u(TICK_SLOW, TICK_FAST);
  localparam int unsigned TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int unsigned IW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [TW-1:0] FAST_END = TW'(TICK_FAST);
  localparam logic [TW-1:0] SLOW_END = TW'(TICK_SLOW);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BIT - 1);

  ch_state_t           state_q, state_d;
  logic [DATA_BIT-1:0] shadow_out_q, shadow_freq_q;
  logic                shadow_mode_q;
  logic [DATA_BIT-1:0] shift_out_q, shift_freq_q;
  logic [TW-1:0]       tick_q;
  logic [IW-1:0]       idx_q;

  logic [DATA_BIT-1:0] eff_out, eff_freq;
  logic                eff_mode;
  logic [TW-1:0]       bit_last;
  logic                bit_end, frame_end;
  logic                load, advance;

  // A write landing on the same edge as a load is seen by that load.
  assign eff_out  = wr ? wr_out  : shadow_out_q;
  assign eff_freq = wr ? wr_freq : shadow_freq_q;
  assign eff_mode = wr ? wr_mode : shadow_mode_q;

  assign bit_last  = shift_freq_q[0] ? FAST_END : SLOW_END;
  assign bit_end   = (state_q == CH_RUN) && (tick_q == bit_last);
  assign frame_end = bit_end && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CH_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    advance    = 1'b0;
    busy       = (state_q == CH_RUN);
    serial_out = (state_q == CH_RUN) && shift_out_q[0];
    bit_tick   = bit_end;
    done_tick  = frame_end && !start && !stop;
    case (state_q)
      CH_IDLE: begin
        if (start && !stop) begin
          state_d = CH_RUN;
          load    = 1'b1;
        end
      end
      CH_RUN: begin
        if (stop) begin
          state_d = CH_IDLE;
        end else if (start) begin
          load = 1'b1;
        end else if (frame_end) begin
          if (eff_mode == REPEAT) load = 1'b1;
          else                    state_d = CH_IDLE;
        end else if (bit_end) begin
          advance = 1'b1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_out_q  <= '0;
      shadow_freq_q <= '0;
      shadow_mode_q <= ONE_SHOT;
      shift_out_q   <= '0;
      shift_freq_q  <= '0;
      tick_q        <= '0;
      idx_q         <= '0;
    end else begin
      if (wr) begin
        shadow_out_q  <= wr_out;
        shadow_freq_q <= wr_freq;
        shadow_mode_q <= wr_mode;
      end
      if (load) begin
        shift_out_q  <= eff_out;
        shift_freq_q <= eff_freq;
        tick_q       <= '0;
        idx_q        <= '0;
      end else if (advance) begin
        shift_out_q  <= shift_out_q >> 1;
        shift_freq_q <= shift_freq_q >> 1;
        tick_q       <= '0;
        idx_q        <= idx_q + IW'(1);
      end else if (state_q == CH_RUN && state_d == CH_IDLE) begin
        shift_out_q  <= '0;
        shift_freq_q <= '0;
        tick_q       <= '0;
        idx_q        <= '0;
      end else if (state_q == CH_RUN) begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/multi_ch_serial_out.sv
// Command dispatcher: latches one command, routes it to the selected channel,
// then acknowledges (flagging an out-of-range channel select).
module multi_ch_serial_out
  import multi_ch_serial_out_pkg::*;
#(
  parameter int unsigned DATA_BIT  = 32,
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned TICK_SLOW = 63,
  parameter int unsigned TICK_FAST = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cmd_valid,
  input  logic [3:0]          i_sel,
  input  logic [DATA_BIT-1:0] i_output_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  output logic                o_cmd_ready,
  output logic                o_cmd_ack,
  output logic                o_cmd_err,
  output logic [CH_NUM-1:0]   o_serial_out,
  output logic [CH_NUM-1:0]   o_bit_tick,
  output logic [CH_NUM-1:0]   o_done_tick,
  output logic [CH_NUM-1:0]   o_busy
);

  disp_state_t         state_q, state_d;
  logic [3:0]          sel_q;
  logic [DATA_BIT-1:0] out_q, freq_q;
  logic                start_q, stop_q, mode_q;
  logic                sel_ok, update;

  assign sel_ok = (int'(sel_q) < int'(CH_NUM));
  assign update = (state_q == S_UPDATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_cmd_ready = 1'b0;
    o_cmd_ack   = 1'b0;
    o_cmd_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) state_d = S_UPDATE;
      end
      S_UPDATE: state_d = S_DONE;
      S_DONE: begin
        o_cmd_ack = 1'b1;
        o_cmd_err = !sel_ok;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      out_q   <= '0;
      freq_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      mode_q  <= ONE_SHOT;
    end else if (state_q == S_IDLE && i_cmd_valid) begin
      sel_q   <= i_sel;
      out_q   <= i_output_pattern;
      freq_q  <= i_freq_pattern;
      start_q <= i_start;
      stop_q  <= i_stop;
      mode_q  <= i_mode;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic hit;
    assign hit = update && (sel_q == 4'(g));

    serial_out_ch #(
      .DATA_BIT (DATA_BIT),
      .TICK_SLOW(TICK_SLOW),
      .TICK_FAST(TICK_FAST)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (hit),
      .wr_out    (out_q),
      .wr_freq   (freq_q),
      .wr_mode   (mode_q),
      .start     (hit && start_q),
      .stop      (hit && stop_q),
      .serial_out(o_serial_out[g]),
      .bit_tick  (o_bit_tick[g]),
      .done_tick (o_done_tick[g]),
      .busy      (o_busy[g])
    );
  end

endmodule

// File: doc/multi_ch_serial_out.md
MULTI_CH_SERIAL_OUT -- requirements
Module: multi_ch_serial_out

Interface
REQ-001 SHALL have parameter DATA_BIT, default 32, bits per pattern frame.
REQ-002 SHALL have parameter CH_NUM, default 4, independent serial channels (1..16).
REQ-003 SHALL have parameter TICK_SLOW, default 63, slow bit period minus one, in clk cycles.
REQ-004 SHALL have parameter TICK_FAST, default 31, fast bit period minus one, in clk cycles.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1, reset asynchronous, active-low.
REQ-006 SHALL have ports: i_cmd_valid in 1, decoded command strobe; i_sel in 4, target channel.
REQ-007 SHALL have ports: i_output_pattern in DATA_BIT, level per bit; i_freq_pattern in DATA_BIT, 1=fast, 0=slow.
REQ-008 SHALL have ports: i_start in 1; i_stop in 1; i_mode in 1, 0=one-shot, 1=repeat.
REQ-009 SHALL have ports: o_cmd_ready out 1; o_cmd_ack out 1; o_cmd_err out 1.
REQ-010 SHALL have ports: o_serial_out out CH_NUM, idle low; o_bit_tick out CH_NUM; o_done_tick out CH_NUM; o_busy out CH_NUM.

Function
REQ-011 Dispatcher FSM SHALL have states S_IDLE, S_UPDATE, S_DONE; o_cmd_ready=1 only in S_IDLE.
REQ-012 S_IDLE: i_cmd_valid=1 at edge k SHALL latch all command fields and enter S_UPDATE; i_cmd_valid outside S_IDLE is ignored.
REQ-013 S_UPDATE (cycle k+1), i_sel<CH_NUM: SHALL write patterns and mode into channel i_sel shadow registers and issue a one-cycle start (if start=1) and/or stop (if stop=1) to that channel only.
REQ-014 S_UPDATE, i_sel>=CH_NUM: SHALL write nothing, issue no start/stop, and pulse o_cmd_err during cycle k+2.
REQ-015 S_DONE (cycle k+2): SHALL pulse o_cmd_ack for one cycle, then return to S_IDLE; next command accepted at edge k+3.
REQ-016 Each channel SHALL have states CH_IDLE, CH_RUN; o_busy=1 exactly in CH_RUN.
REQ-017 Start in CH_IDLE SHALL load shift registers from shadow at edge k+2, drive bit 0 on o_serial_out from cycle k+2.
REQ-018 Bits SHALL be sent LSB first; bit n held TICK_FAST+1 cycles if freq bit n=1, else TICK_SLOW+1 cycles.
REQ-019 o_bit_tick SHALL pulse during the last cycle of each bit.
REQ-020 After bit DATA_BIT-1, one-shot: o_done_tick pulses with the last bit tick, output goes low, CH_IDLE next cycle.
REQ-021 After bit DATA_BIT-1, repeat: o_done_tick pulses, shift registers reload from current shadow, bit 0 follows with no gap cycle.
REQ-022 Shadow writes during CH_RUN SHALL not alter the frame in flight; they take effect at the next repeat reload or start.
REQ-023 Start during CH_RUN SHALL restart at bit 0 with the new shadow contents, no o_done_tick for the aborted frame.
REQ-024 Stop SHALL force output low and CH_IDLE at the next edge, no o_done_tick; stop in CH_IDLE is a no-op.
REQ-025 Simultaneous start and stop to one channel: stop SHALL win.
REQ-026 Channels SHALL run independently; commands to one channel never disturb another's timing.
REQ-027 Bit-period counter width SHALL be clog2(max(TICK_SLOW,TICK_FAST)+1); bit index width clog2(DATA_BIT).

Reset
REQ-028 rst_n low SHALL asynchronously clear FSM to S_IDLE, all channels to CH_IDLE, all shadow/shift registers and counters to 0.
REQ-029 During and after reset: o_serial_out=0, o_bit_tick=0, o_done_tick=0, o_busy=0, o_cmd_ack=0, o_cmd_err=0, o_cmd_ready=1.
REQ-030 Reset asserted mid-frame SHALL abort immediately with output low; no pulses on deassertion.

Structure
REQ-031 Shared package SHALL hold dispatcher and channel state encodings and the mode constants ONE_SHOT=0, REPEAT=1.
REQ-032 One sub-module serial_out_ch (single channel engine) SHALL be instantiated CH_NUM times via generate.
REQ-033 Top level SHALL hold only dispatcher FSM and command latch.

Verification (DATA_BIT=8, CH_NUM=4, TICK_SLOW=3, TICK_FAST=1)
REQ-034 Ch0 one-shot, out=8'hA5, freq=8'h0F, start -> 1,0,1,0 at 2 cycles each, then 0,1,0,1 at 4 cycles each, 24 cycles total; one done tick; busy drops.
REQ-035 Ch1 repeat, out=8'hFF, freq=8'hFF -> continuous high, done tick every 16 cycles; stop mid-frame -> low next cycle, no done tick.
REQ-036 i_sel=7 -> o_cmd_err and o_cmd_ack pulse at k+2; no channel busy; i_cmd_valid held during S_UPDATE ignored.
REQ-037 Ch2 repeat running; write out=8'h00 without start -> current frame unchanged, next frame all low.
REQ-038 Ch0 and ch3 started back-to-back with different freq -> independent bit ticks; rst_n low mid-frame -> all outputs 0 asynchronously.
